// File: rtl/lms_rx_deframer.sv
`default_nettype none
// ============================================================================
// lms_rx_deframer : LMS RX interleaved I/Q deframer with IQSEL lock tracking.
// Optional macro LMS_DEFRAME_ERRCNT_EN builds err_count / clr_err.  Rev 1.0
// ============================================================================
module lms_rx_deframer #(
  parameter int WIDTH      = 12,
  parameter int LOCK_PAIRS = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             swap_iq,
  input  logic             iqsel_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] i_out,
  output logic [WIDTH-1:0] q_out,
  output logic             strobe,
  output logic             locked,
  output logic             frame_err,
  input  logic             clr_err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_PAIRS);

  state_t           state;
  logic             sel_r;
  logic             sel_prev;
  logic [WIDTH-1:0] dat_r;
  logic [WIDTH-1:0] i_hold;
  logic [3:0]       pair_cnt;
  logic [3:0]       pair_nxt;
  logic             sel_eff;
  logic             repeat_sel;
  logic             fault;

  assign sel_eff    = sel_r ^ swap_iq;
  assign repeat_sel = (sel_eff == sel_prev);
  assign pair_nxt   = pair_cnt + 4'd1;
  assign fault      = enable && (state == LOCKED) && repeat_sel;

  // Pin capture stage; sel_prev tracks the swapped view so alternation is checked post-swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r    <= 1'b0;
      dat_r    <= '0;
      sel_prev <= 1'b0;
    end else begin
      sel_r    <= iqsel_in;
      dat_r    <= data_in;
      sel_prev <= sel_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      pair_cnt  <= 4'd0;
      i_hold    <= '0;
      i_out     <= '0;
      q_out     <= '0;
      strobe    <= 1'b0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      strobe    <= 1'b0;
      frame_err <= 1'b0;
      if (!enable) begin
        state    <= HUNT;
        pair_cnt <= 4'd0;
        locked   <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            locked <= 1'b0;
            if (sel_eff) begin
              i_hold   <= dat_r;
              pair_cnt <= 4'd0;
              state    <= LOCKING;
            end
          end
          LOCKING: begin
            if (repeat_sel) begin
              state    <= HUNT;
              pair_cnt <= 4'd0;
            end else if (sel_eff) begin
              i_hold <= dat_r;
            end else if (pair_nxt == LOCK_TARGET) begin
              // The pair that completes the lock run is also the first one delivered.
              state    <= LOCKED;
              locked   <= 1'b1;
              strobe   <= 1'b1;
              i_out    <= i_hold;
              q_out    <= dat_r;
              pair_cnt <= 4'd0;
            end else begin
              pair_cnt <= pair_nxt;
            end
          end
          LOCKED: begin
            if (repeat_sel) begin
              frame_err <= 1'b1;
              locked    <= 1'b0;
              state     <= HUNT;
              pair_cnt  <= 4'd0;
            end else if (sel_eff) begin
              i_hold <= dat_r;
            end else begin
              strobe <= 1'b1;
              i_out  <= i_hold;
              q_out  <= dat_r;
            end
          end
          default: begin
            state    <= HUNT;
            pair_cnt <= 4'd0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef LMS_DEFRAME_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt;

  // Clear takes priority over a coincident fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (fault && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign err_count = err_cnt;
`else
  logic unused_errcnt_inputs;
  assign unused_errcnt_inputs = clr_err ^ fault;
  assign err_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lms_rx_deframer.sv
`default_nettype none
// ============================================================================
// tb_lms_rx_deframer : directed stimulus with a strobe-driven scoreboard.  Rev 1.0
// ============================================================================
module tb_lms_rx_deframer;

  localparam int WIDTH      = 12;
  localparam int LOCK_PAIRS = 4;
  localparam int ERR_W      = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             swap_iq;
  logic             iqsel_in;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] i_out;
  logic [WIDTH-1:0] q_out;
  logic             strobe;
  logic             locked;
  logic             frame_err;
  logic             clr_err;
  logic [ERR_W-1:0] err_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_cnt = 0;
  logic prev_strobe = 1'b0;
  logic [WIDTH-1:0] last_i = '0;
  logic [WIDTH-1:0] last_q = '0;

  typedef struct {
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] q;
    int               at;
  } exp_t;
  exp_t sbq[$];

  lms_rx_deframer #(
    .WIDTH(WIDTH), .LOCK_PAIRS(LOCK_PAIRS), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .swap_iq(swap_iq),
    .iqsel_in(iqsel_in), .data_in(data_in), .i_out(i_out), .q_out(q_out),
    .strobe(strobe), .locked(locked), .frame_err(frame_err),
    .clr_err(clr_err), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Present one word on the pins; returns 1 ns after the capturing edge.
  task automatic drive(input logic sel, input logic [WIDTH-1:0] d);
    iqsel_in = sel;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  // Strobe for a pair whose Q is captured at edge E is expected right after edge E+1.
  task automatic pair(input logic [WIDTH-1:0] iw, input logic [WIDTH-1:0] qw, input bit push);
    exp_t e;
    logic s;
    s = ~swap_iq;
    drive(s, iw);
    drive(~s, qw);
    if (push) begin
      e.i = iw; e.q = qw; e.at = cyc + 1;
      sbq.push_back(e);
      last_i = iw; last_q = qw;
    end
  endtask

  task automatic relock(input logic [WIDTH-1:0] ib, input logic [WIDTH-1:0] qb);
    for (int n = 0; n < LOCK_PAIRS; n++) begin
      pair(ib + WIDTH'(n), qb + WIDTH'(n), n == LOCK_PAIRS - 1);
      if (n == LOCK_PAIRS - 2) check("locked_before_run_done", locked, 0);
    end
  endtask

  task automatic fault_seq(input bit clr);
    logic s;
    s = ~swap_iq;
    drive(s, 12'hA5A);
    check("locked_before_fault", locked, 1);
    drive(s, 12'hA5B);
    clr_err = clr;
    drive(~s, 12'h5A5);
    clr_err = 1'b0;
`ifdef LMS_DEFRAME_ERRCNT_EN
    if (exp_cnt < 3) exp_cnt++;
    if (clr) exp_cnt = 0;
`endif
    check("fault_frame_err", frame_err, 1);
    check("fault_locked_drop", locked, 0);
    check("fault_err_count", err_count, exp_cnt);
    drive(~s, 12'h222);
    check("frame_err_one_cycle", frame_err, 0);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected pair and its cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (strobe) begin
        check("strobe_not_back_to_back", prev_strobe, 0);
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe i_out=%0h q_out=%0h cycle=%0d required=no strobe", i_out, q_out, cyc);
        end else begin
          e = sbq.pop_front();
          check("pair_i", i_out, e.i);
          check("pair_q", q_out, e.q);
          check("strobe_cycle", cyc, e.at);
        end
      end else if (sbq.size() > 0 && sbq[0].at < cyc) begin
        e = sbq.pop_front();
        total++; bad++;
        $display("FAIL missed_strobe actual=none required=%0h/%0h at cycle %0d", e.i, e.q, e.at);
      end
      prev_strobe = strobe;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0; enable = 1'b0; swap_iq = 1'b0;
    iqsel_in = 1'b0; data_in = '0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_i_out", i_out, 0);
    check("rst_q_out", q_out, 0);
    check("rst_strobe", strobe, 0);
    check("rst_locked", locked, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_count", err_count, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Clean lock: 4th pair is 0x123/0x456, then steady stream.
    relock(12'h120, 12'h453);
    pair(12'h123, 12'h456, 1);
    pair(12'h123, 12'h456, 1);

    // Fault while locked, then re-lock on 4 fresh pairs.
    fault_seq(0);
    relock(12'h210, 12'h310);

    // Glitch while still locking: no error, lock needs 4 new pairs.
    fault_seq(0);
    pair(12'h011, 12'h022, 0);
    pair(12'h033, 12'h044, 0);
    drive(1'b1, 12'h0AA);
    drive(1'b1, 12'h0BB);
    drive(1'b0, 12'h0CC);
    check("glitch_frame_err", frame_err, 0);
    check("glitch_locked", locked, 0);
    check("glitch_err_count", err_count, exp_cnt);
    relock(12'h400, 12'h500);

    // Repeated faults drive the 2-bit counter into saturation.
    for (int f = 0; f < 5; f++) begin
      fault_seq(0);
      relock(12'h600 + WIDTH'(f * 16), 12'h700 + WIDTH'(f * 16));
    end
    fault_seq(1);
    relock(12'h800, 12'h900);

    // Enable drop while locked: locked falls next edge, outputs hold.
    drive(1'b1, 12'h0F0);
    check("en_locked_before", locked, 1);
    enable = 1'b0;
    drive(1'b0, 12'h0F1);
    check("en_drop_locked", locked, 0);
    check("en_hold_i", i_out, last_i);
    check("en_hold_q", q_out, last_q);
    drive(1'b1, 12'h0F2);

    // Swapped IQSEL sense: the IQSEL=0 word is I.
    swap_iq = 1'b1;
    enable  = 1'b1;
    relock(12'h453, 12'h120);
    pair(12'h456, 12'h123, 1);

    // Reset between the I and Q words of a pair.
    drive(1'b0, 12'h777);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    check("midrst_i_out", i_out, 0);
    check("midrst_q_out", q_out, 0);
    check("midrst_strobe", strobe, 0);
    check("midrst_locked", locked, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_err_count", err_count, 0);
    swap_iq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 12'h778);
    relock(12'h300, 12'h600);
    pair(12'h3AB, 12'h6CD, 1);
    drive(1'b1, 12'h000);
    enable = 1'b0;
    repeat (3) drive(1'b0, 12'h000);
    check("scoreboard_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
